capture_buffer: RTL and testbench
=================================

// Module: capture_buffer
// PURPOSE
// - Downstream of the trigger block in the logic-analyser datapath; consumes its `triggered` pulse.
// - Stores samples in a circular RAM, then freezes a window of pre-trigger and post-trigger samples.
// - Drives the trigger block's `ignore` input until the pre-trigger history is full.
// - Exposes a 1-cycle-latency random-access readout of the frozen window.
// PARAMETERS
// dsize   32  sample width (matches trigger dsize)
// aw      10  buffer address width; depth D = 2**aw
// PORTS
// clk            in   1      sample clock, all logic on rising edge
// reset          in   1      asynchronous, active-high; clears all state
// dinput         in   dsize  sample data, same bus fed to trigger
// sample_en      in   1      qualifies dinput this cycle
// arm            in   1      start capture (pulse)
// abort          in   1      cancel capture (pulse)
// triggered      in   1      trigger hit from trigger block
// pre_count      in   aw     requested pre-trigger samples, latched on arm
// post_count     in   aw     requested post-trigger samples incl. trigger sample, latched on arm
// ignore         out  1      high in FILL: trigger must not fire yet
// busy           out  1      high in FILL/WAIT/POST
// done           out  1      high in DONE, window frozen
// cap_len        out  aw+1   samples in frozen window (pre_eff+post_eff)
// trig_index     out  aw     window index of trigger sample (=pre_eff)
// rd_en          in   1      read request (honoured in DONE only)
// rd_index       in   aw+1   window-relative index, 0 = oldest
// rd_valid       out  1      rd_data valid, 1 cycle after rd_en
// rd_data        out  dsize  read data
// BEHAVIOUR
// - Reset: state IDLE; ignore, busy, done, rd_valid = 0; cap_len, trig_index, rd_data = 0; pointers 0.
// - States: IDLE -> FILL -> WAIT -> POST -> DONE.
// - IDLE/DONE + arm:
//   - latch pre_eff = min(pre_count, D-1); post_eff = max(post_count, 1), clamped to D-pre_eff.
//   - Clear wptr/fill count; go FILL, or WAIT if pre_eff = 0.
// - FILL/WAIT/POST, sample_en=1: write dinput at wptr; wptr++ mod D (wraps freely).
// - FILL: count written samples; at count = pre_eff (after that write) -> WAIT. triggered ignored.
// - WAIT: triggered & sample_en -> the sample written this cycle is the trigger sample.
//   - Record tptr = wptr; post counter = 1; go POST, or DONE if post_eff = 1.
//   - triggered without sample_en is ignored.
// - POST: each sample_en post counter++; at post_eff -> DONE. triggered ignored.
// - DONE:
//   - cap_len/trig_index valid; start = tptr - pre_eff mod D.
//   - No RAM writes; sample_en ignored.
// - Readout: rd_en in DONE -> next cycle rd_valid=1 and:
//   - rd_index < cap_len: rd_data = RAM[(start + rd_index) mod D]
//   - rd_index >= cap_len: rd_data = 0
//   - rd_en outside DONE: rd_valid stays 0.
// - abort (any state): next state IDLE, done=0, cap_len/trig_index cleared.
// - abort and arm same cycle: abort wins.
// - arm in FILL/WAIT/POST: ignored (no restart).
// - Async reset mid-capture: immediate return to reset values; RAM contents undefined.
// - Inferred single-port-write / registered-read RAM. No read/write collision: reads only in DONE.
// CONFIGURATION
// CAPBUF_TIMESTAMP_EN:
// - Defined: adds 32-bit free-running sample counter (++ per sample_en in FILL/WAIT/POST, cleared on arm),
//   plus output trig_timestamp[31:0] = counter value of the trigger sample; 0 on reset/abort/arm.
// - Undefined: no counter, no trig_timestamp port.
// TESTING
// - pre=4, post=4, D=16, ramp dinput=n, trigger at n=10 -> cap_len=8, trig_index=4; reads 0..7 = 6..13.
// - pre=0, post=1, trigger at n=3 -> ignore never high; done 1 cycle after trigger; read0=3, cap_len=1.
// - pre=3: triggered pulsed at n=1 (in FILL) -> ignored; second pulse at n=20 -> read0=17, trig_index=3.
// - pre=12, post=12, D=16 -> post_eff=4, cap_len=16; wptr wrap gives contiguous ascending reads.
// - abort in POST -> next cycle busy=0, done=0; rd_en gives no rd_valid. arm+abort same cycle -> stays IDLE.
// - sample_en low every other cycle, pre=2/post=2 -> only qualified samples stored; rd_index=9 -> rd_data=0.

Source files
------------

// File: rtl/capture_buffer.sv
// Logic-analyser capture buffer: circular sample RAM that freezes a pre/post-trigger window for readout.
// Optional CAPBUF_TIMESTAMP_EN adds a per-sample counter and the trig_timestamp output.
module capture_buffer #(
  parameter int dsize = 32,
  parameter int aw    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [dsize-1:0] dinput,
  input  logic             sample_en,
  input  logic             arm,
  input  logic             abort,
  input  logic             triggered,
  input  logic [aw-1:0]    pre_count,
  input  logic [aw-1:0]    post_count,
  output logic             ignore,
  output logic             busy,
  output logic             done,
  output logic [aw:0]      cap_len,
  output logic [aw-1:0]    trig_index,
  input  logic             rd_en,
  input  logic [aw:0]      rd_index,
  output logic             rd_valid,
  output logic [dsize-1:0] rd_data
`ifdef CAPBUF_TIMESTAMP_EN
  ,
  output logic [31:0]      trig_timestamp
`endif
);

  localparam logic [aw:0] DEPTH = {1'b1, {aw{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WAIT, S_POST, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [aw-1:0]   wptr_q, wptr_d;
  logic [aw-1:0]   tptr_q, tptr_d;
  logic [aw-1:0]   pre_q, pre_d;
  logic [aw-1:0]   post_q, post_d;
  logic [aw-1:0]   cnt_q, cnt_d;
  logic [aw-1:0]   cnt_inc;
  logic [aw:0]     post_req, post_lim, post_sel;
  logic            capturing, we, rd_go;
  logic [aw-1:0]   start_ptr, rd_addr;
  logic [aw:0]     cap_len_w;
  logic            rd_valid_q, in_range_q;
  logic [dsize-1:0] ram_q;
  logic [dsize-1:0] mem [DEPTH];
`ifdef CAPBUF_TIMESTAMP_EN
  logic [31:0]     ts_q, ts_d, trig_ts_q, trig_ts_d;
`endif

  // post window is at least the trigger sample and never longer than what fits after pre
  assign post_req  = (post_count == '0) ? {{aw{1'b0}}, 1'b1} : {1'b0, post_count};
  assign post_lim  = DEPTH - {1'b0, pre_count};
  assign post_sel  = (post_req > post_lim) ? post_lim : post_req;

  assign capturing = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
  assign we        = capturing && sample_en && !abort;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    tptr_d  = tptr_q;
    pre_d   = pre_q;
    post_d  = post_q;
    cnt_d   = cnt_q;
`ifdef CAPBUF_TIMESTAMP_EN
    ts_d      = ts_q;
    trig_ts_d = trig_ts_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
`ifdef CAPBUF_TIMESTAMP_EN
      trig_ts_d = '0;
`endif
    end else begin
      if (we) begin
        wptr_d = wptr_q + 1'b1;
`ifdef CAPBUF_TIMESTAMP_EN
        ts_d = ts_q + 32'd1;
`endif
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            pre_d   = pre_count;
            post_d  = post_sel[aw-1:0];
            wptr_d  = '0;
            cnt_d   = '0;
            state_d = (pre_count == '0) ? S_WAIT : S_FILL;
`ifdef CAPBUF_TIMESTAMP_EN
            ts_d      = '0;
            trig_ts_d = '0;
`endif
          end
        end
        S_FILL: begin
          if (sample_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_q) state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (sample_en && triggered) begin
            tptr_d  = wptr_q;
            cnt_d   = aw'(1);
            state_d = (post_q == aw'(1)) ? S_DONE : S_POST;
`ifdef CAPBUF_TIMESTAMP_EN
            trig_ts_d = ts_q;
`endif
          end
        end
        S_POST: begin
          if (sample_en) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_q) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      tptr_q     <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      in_range_q <= 1'b0;
`ifdef CAPBUF_TIMESTAMP_EN
      ts_q       <= '0;
      trig_ts_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      tptr_q     <= tptr_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_go;
      in_range_q <= rd_index < cap_len_w;
`ifdef CAPBUF_TIMESTAMP_EN
      ts_q       <= ts_d;
      trig_ts_q  <= trig_ts_d;
`endif
    end
  end

  // window starts pre_eff samples before the trigger sample, wrapping mod depth
  assign start_ptr = tptr_q - pre_q;
  assign rd_addr   = start_ptr + rd_index[aw-1:0];
  assign cap_len_w = {1'b0, pre_q} + {1'b0, post_q};
  assign rd_go     = rd_en && (state_q == S_DONE);

  // RAM kept free of reset so it maps onto block memory
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= dinput;
    if (rd_go) ram_q <= mem[rd_addr];
  end

  assign ignore     = (state_q == S_FILL);
  assign busy       = capturing;
  assign done       = (state_q == S_DONE);
  assign cap_len    = done ? cap_len_w : '0;
  assign trig_index = done ? pre_q : '0;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = (rd_valid_q && in_range_q) ? ram_q : '0;
`ifdef CAPBUF_TIMESTAMP_EN
  assign trig_timestamp = trig_ts_q;
`endif

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: model keeps the list of qualified samples and derives the window from it.
module tb_capture_buffer;
  localparam int AW = 4;
  localparam int D  = 16;

  logic        clk = 0, reset = 0;
  logic [31:0] dinput = 0;
  logic        sample_en = 0, arm = 0, abort = 0, triggered = 0;
  logic [AW-1:0] pre_count = 0, post_count = 0;
  logic        ignore, busy, done;
  logic [AW:0] cap_len;
  logic [AW-1:0] trig_index;
  logic        rd_en = 0;
  logic [AW:0] rd_index = 0;
  logic        rd_valid;
  logic [31:0] rd_data;
`ifdef CAPBUF_TIMESTAMP_EN
  logic [31:0] trig_ts;
`endif

  capture_buffer #(.dsize(32), .aw(AW)) dut (
    .clk(clk), .reset(reset), .dinput(dinput), .sample_en(sample_en),
    .arm(arm), .abort(abort), .triggered(triggered),
    .pre_count(pre_count), .post_count(post_count),
    .ignore(ignore), .busy(busy), .done(done),
    .cap_len(cap_len), .trig_index(trig_index),
    .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid), .rd_data(rd_data)
`ifdef CAPBUF_TIMESTAMP_EN
    , .trig_timestamp(trig_ts)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t sb[$];

  // monitor: every rd_valid must match the oldest outstanding read, on time
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      chk("rd_valid_missing", 0, 1);
      void'(sb.pop_front());
    end
    if (rd_valid) begin
      if (sb.size() == 0) chk("rd_valid_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rd_latency", cyc, e.due);
        chk("rd_data", rd_data, e.data);
      end
    end
  end

  // reference model: qualified samples since arm; trigger is first hit at index >= pre_eff
  logic [31:0] samples[$];
  int pre_e, post_e, trig_k, nval;
  bit mdone;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int pre, input int post);
    pre_count = AW'(pre);
    post_count = AW'(post);
    arm = 1;
    step();
    arm = 0;
    pre_e  = pre;
    post_e = (post < 1) ? 1 : post;
    if (post_e > D - pre_e) post_e = D - pre_e;
    samples.delete();
    trig_k = -1;
    mdone = 0;
    chk("arm_ignore", ignore, pre_e > 0);
    chk("arm_busy", busy, 1);
    chk("arm_done", done, 0);
  endtask

  task automatic run(input int sen_mode, input int trig_val, input int early_val,
                     input bit rnd_ctl, input int limit, input bit expect_done);
    for (int c = 0; c < limit && !mdone; c++) begin
      bit se, tr;
      logic [31:0] d;
      int sz;
      se = (sen_mode == 0) ? 1'b1 : (sen_mode == 1) ? (c % 2 == 0) : ($urandom % 3 != 0);
      d  = se ? nval : $urandom;
      if (trig_val >= 0) tr = se && (nval == trig_val || nval == early_val);
      else tr = ($urandom % 5 == 0);
      dinput = d;
      sample_en = se;
      triggered = tr;
      if (rnd_ctl) begin
        arm = ($urandom % 8 == 0);
        pre_count = AW'($urandom);
        post_count = AW'($urandom);
      end
      step();
      if (se) begin
        samples.push_back(d);
        nval++;
        sz = samples.size();
        if (tr && trig_k < 0 && sz - 1 >= pre_e) trig_k = sz - 1;
        if (trig_k >= 0 && sz == trig_k + post_e) mdone = 1;
      end
      chk("ignore", ignore, !mdone && samples.size() < pre_e);
      chk("busy", busy, !mdone);
      chk("done", done, mdone);
    end
    arm = 0; sample_en = 0; triggered = 0;
    if (expect_done) begin
      chk("capture_done", done, 1);
      chk("cap_len", cap_len, pre_e + post_e);
      chk("trig_index", trig_index, pre_e);
`ifdef CAPBUF_TIMESTAMP_EN
      chk("trig_timestamp", trig_ts, trig_k);
`endif
    end
  endtask

  task automatic read_one(input int idx);
    exp_t e;
    int cap;
    cap = pre_e + post_e;
    e.data = (idx < cap && trig_k >= 0) ? samples[trig_k - pre_e + idx] : 32'd0;
    e.due  = cyc + 1;
    sb.push_back(e);
    rd_en = 1;
    rd_index = (AW+1)'(idx);
    step();
    rd_en = 0;
  endtask

  task automatic do_reads();
    int cap;
    cap = pre_e + post_e;
    for (int i = 0; i < cap; i++) read_one(i);
    read_one(cap);
    read_one(9);
    read_one(2 * D - 1);
    step();
    step();
  endtask

  initial begin
    reset = 1;
    step(); step();
    reset = 0;
    step();
    chk("rst_ignore", ignore, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cap_len", cap_len, 0);
    chk("rst_trig_index", trig_index, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);

    // ramp with trigger at 10: window 6..13
    nval = 0; do_arm(4, 4); run(0, 10, -1, 0, 400, 1); do_reads();
    // no pre-trigger history, single-sample window
    nval = 0; do_arm(0, 1); run(0, 3, -1, 0, 400, 1); do_reads();
    // early trigger while filling is ignored
    nval = 0; do_arm(3, 4); run(0, 20, 1, 0, 400, 1); do_reads();
    // oversize request clamps post and fills the whole buffer across a wrap
    nval = 0; do_arm(12, 12); run(0, 20, -1, 0, 400, 1); do_reads();
    // sparse sample_en
    nval = 0; do_arm(2, 2); run(1, 7, -1, 0, 400, 1); do_reads();

    // abort during POST
    nval = 0; do_arm(2, 8); run(0, 5, -1, 0, 8, 0);
    chk("pre_abort_busy", busy, 1);
    abort = 1; step(); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cap_len", cap_len, 0);
    chk("abort_trig_index", trig_index, 0);
    rd_en = 1; rd_index = 0; step(); rd_en = 0; step(); step();
    // arm and abort together: abort wins
    pre_count = 3; post_count = 3; arm = 1; abort = 1; step(); arm = 0; abort = 0;
    chk("armabort_busy", busy, 0);
    chk("armabort_ignore", ignore, 0);
    step();
    chk("armabort_busy2", busy, 0);

    // randomized captures with stray arm/pre/post activity during capture
    for (int t = 0; t < 8; t++) begin
      nval = $urandom % 1000;
      do_arm($urandom % 16, $urandom % 16);
      run(2, -1, -1, 1, 600, 1);
      do_reads();
    end

    // asynchronous reset mid-capture
    nval = 0; do_arm(5, 5); run(0, 100, -1, 0, 3, 0);
    #2 reset = 1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ignore", ignore, 0);
    @(negedge clk) reset = 0;
    step();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);

    step(); step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
